// File: rtl/nubus_pkg.sv
// ---------------------------------------------------------------------------
// nubus_pkg
// Shared types and constants for the NuBus slave transaction controller.
//   status_e      : NuBus acknowledge status codes driven on {tm1_o, tm0_o}
//   state_e       : controller FSM states
//   SLOT_PREFIX   : top nibble of standard slot space (0xFsxx_xxxx)
//   SUPER_BIT     : Wishbone word-address bit flagging super-slot space
//   wb_word_addr  : builds the 30-bit Wishbone word address from a NuBus address
// ---------------------------------------------------------------------------
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_COMPLETE = 2'b00,
    ST_ERROR    = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_RETRY    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WB,
    S_RESP
  } state_e;

  localparam logic [3:0] SLOT_PREFIX = 4'hF;
  localparam int         SUPER_BIT   = 29;
  localparam int         TMO_W       = 10;

  // Only the offset inside the addressed space is forwarded: 24 bits of byte
  // offset for standard slot space, 28 bits for super-slot space. The slot
  // number itself never reaches the internal bus, so every card sees its own
  // space starting at word 0.
  function automatic logic [29:0] wb_word_addr(input logic [31:0] ad,
                                               input logic        super_hit);
    logic [29:0] a;
    a = '0;
    if (super_hit) begin
      a[25:0]      = ad[27:2];
      a[SUPER_BIT] = 1'b1;
    end else begin
      a[21:0] = ad[23:2];
    end
    return a;
  endfunction

endpackage

// File: rtl/nubus_slave_ctrl_if.sv
// ---------------------------------------------------------------------------
// nubus_slave_ctrl_if
// Bundles the sampled NuBus signals, the NuBus response signals and the
// Wishbone classic master bus of the slave controller.
//   NuBus in  : nub_idn, tm0, tm1, start, ack, ad, sel, block
//   NuBus out : ack_o, tm1_o, tm0_o, ad_o, ad_oe
//   Wishbone  : wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w (out)
//               wb_dat_r, wb_ack, wb_err (in)
// Modports: slave  = the controller's view
//           master = the environment (NuBus sampling stage + Wishbone slave)
// ---------------------------------------------------------------------------
interface nubus_slave_ctrl_if;

  logic [3:0]  nub_idn;
  logic        tm0;
  logic        tm1;
  logic        start;
  logic        ack;
  logic [31:0] ad;
  logic [3:0]  sel;
  logic        block;

  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [29:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;

  logic        ack_o;
  logic        tm1_o;
  logic        tm0_o;
  logic [31:0] ad_o;
  logic        ad_oe;

  modport slave (
    input  nub_idn, tm0, tm1, start, ack, ad, sel, block,
    input  wb_dat_r, wb_ack, wb_err,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
    output ack_o, tm1_o, tm0_o, ad_o, ad_oe
  );

  modport master (
    output nub_idn, tm0, tm1, start, ack, ad, sel, block,
    output wb_dat_r, wb_ack, wb_err,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
    input  ack_o, tm1_o, tm0_o, ad_o, ad_oe
  );

endinterface

// File: rtl/nubus_slot_decode.sv
// ---------------------------------------------------------------------------
// nubus_slot_decode
// Combinational address decode for this card's slot.
//   slot_i   : 4-bit slot number (true polarity)
//   ad_top_i : ad[31:24] of the start cycle
//   hit_o    : address lies in this card's standard or super-slot space
//   super_o  : address lies in this card's super-slot space
// ---------------------------------------------------------------------------
module nubus_slot_decode
  import nubus_pkg::*;
#(
  parameter int SUPER_EN = 1
) (
  input  logic [3:0] slot_i,
  input  logic [7:0] ad_top_i,
  output logic       hit_o,
  output logic       super_o
);

  logic std_hit;
  logic super_hit;
  logic super_en;

  assign super_en = (SUPER_EN != 0);

  assign std_hit = (ad_top_i == {SLOT_PREFIX, slot_i});

  // Slot F has no super space: 0xF000_0000 upward is standard slot space.
  assign super_hit = super_en && (ad_top_i[7:4] == slot_i) && (slot_i != SLOT_PREFIX);

  assign hit_o   = std_hit | super_hit;
  assign super_o = super_hit;

endmodule

// File: rtl/nubus_slave_ctrl.sv
// ---------------------------------------------------------------------------
// nubus_slave_ctrl
// Converts single-beat NuBus reads/writes addressed to this slot into one
// Wishbone classic cycle and returns the NuBus acknowledge with a status.
// Block transfers are refused with error status.
//   nub_clkn   : NuBus clock, all flops update on its falling edge
//   nub_resetn : asynchronous active-low reset
//   bus        : NuBus + Wishbone signals (nubus_slave_ctrl_if.slave)
// Parameters:
//   WB_TIMEOUT : Wishbone cycles allowed before a timeout response (1..1023)
//   SUPER_EN   : also respond in super-slot space
// ---------------------------------------------------------------------------
module nubus_slave_ctrl
  import nubus_pkg::*;
#(
  parameter int WB_TIMEOUT = 255,
  parameter int SUPER_EN   = 1
) (
  input  logic                  nub_clkn,
  input  logic                  nub_resetn,
  nubus_slave_ctrl_if.slave     bus
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(WB_TIMEOUT);

  logic [3:0] slot;
  logic       hit;
  logic       super_hit;
  logic       req_hit;
  logic       tmo_reached;
  logic       unused_tm0;

  state_e           state_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             wb_cyc_q;
  logic             wb_we_q;
  logic [29:0]      wb_adr_q;
  logic [3:0]       wb_sel_q;
  logic [31:0]      wb_dat_w_q;
  logic             ack_o_q;
  status_e          status_q;
  logic [31:0]      ad_o_q;
  logic             ad_oe_q;

  // Transfer size is carried by the byte selects, so tm0 is not needed.
  assign unused_tm0 = bus.tm0;

  assign slot = ~bus.nub_idn;

  nubus_slot_decode #(
    .SUPER_EN (SUPER_EN)
  ) u_decode (
    .slot_i   (slot),
    .ad_top_i (bus.ad[31:24]),
    .hit_o    (hit),
    .super_o  (super_hit)
  );

  // A start with ack also set is an attention cycle, never a transaction.
  assign req_hit     = bus.start & ~bus.ack & hit;
  assign tmo_reached = (tmo_cnt_q >= TMO_LIMIT);

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= '0;
      wb_cyc_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= '0;
      wb_sel_q   <= '0;
      wb_dat_w_q <= '0;
      ack_o_q    <= 1'b0;
      status_q   <= ST_COMPLETE;
      ad_o_q     <= '0;
      ad_oe_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_hit) begin
            if (bus.block) begin
              state_q  <= S_RESP;
              ack_o_q  <= 1'b1;
              status_q <= ST_ERROR;
            end else begin
              wb_adr_q <= wb_word_addr(bus.ad, super_hit);
              wb_we_q  <= bus.tm1;
              wb_sel_q <= bus.tm1 ? bus.sel : 4'hF;
              if (bus.tm1) begin
                state_q <= S_WDATA;
              end else begin
                state_q   <= S_WB;
                wb_cyc_q  <= 1'b1;
                tmo_cnt_q <= '0;
              end
            end
          end
        end

        // Write data follows the address cycle on the same ad lines.
        S_WDATA: begin
          wb_dat_w_q <= bus.ad;
          state_q    <= S_WB;
          wb_cyc_q   <= 1'b1;
          tmo_cnt_q  <= '0;
        end

        S_WB: begin
          if (bus.wb_err) begin
            // err is checked before ack so a slave asserting both reports error
            state_q  <= S_RESP;
            wb_cyc_q <= 1'b0;
            ack_o_q  <= 1'b1;
            status_q <= ST_ERROR;
          end else if (bus.wb_ack) begin
            state_q  <= S_RESP;
            wb_cyc_q <= 1'b0;
            ack_o_q  <= 1'b1;
            status_q <= ST_COMPLETE;
            if (!wb_we_q) begin
              ad_o_q  <= bus.wb_dat_r;
              ad_oe_q <= 1'b1;
            end
          end else if (tmo_reached) begin
            state_q  <= S_RESP;
            wb_cyc_q <= 1'b0;
            ack_o_q  <= 1'b1;
            status_q <= ST_TIMEOUT;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          state_q  <= S_IDLE;
          ack_o_q  <= 1'b0;
          ad_oe_q  <= 1'b0;
          ad_o_q   <= '0;
          status_q <= ST_COMPLETE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wb_cyc   = wb_cyc_q;
  assign bus.wb_stb   = wb_cyc_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_adr   = wb_adr_q;
  assign bus.wb_sel   = wb_sel_q;
  assign bus.wb_dat_w = wb_dat_w_q;
  assign bus.ack_o    = ack_o_q;
  assign bus.tm1_o    = status_q[1];
  assign bus.tm0_o    = status_q[0];
  assign bus.ad_o     = ad_o_q;
  assign bus.ad_oe    = ad_oe_q;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nubus_slave_ctrl
// Self-checking bench for nubus_slave_ctrl: directed transactions followed by
// randomized ones, each predicted from the NuBus/Wishbone transaction rules
// (address decode, response latency, status, data) and compared cycle by
// cycle against the DUT. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_nubus_slave_ctrl;

  localparam int         T        = 4;
  localparam int         SUPER_EN = 1;
  localparam logic [3:0] MY_SLOT  = 4'h9;

  // Wishbone responder behaviours
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;
  localparam int M_BOTH = 3;

  logic nub_clkn = 1'b1;
  logic nub_resetn;
  int   tests_run    = 0;
  int   tests_failed = 0;

  nubus_slave_ctrl_if bus();

  nubus_slave_ctrl #(
    .WB_TIMEOUT (T),
    .SUPER_EN   (SUPER_EN)
  ) dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .bus        (bus)
  );

  always #5 nub_clkn = ~nub_clkn;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one NuBus start cycle at the current rising edge (DUT samples on
  // the following falling edge) and plays the Wishbone slave. Returns at the
  // edge where a back-to-back start may already be driven.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [3:0] bsel, input logic blk, input logic attn,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int dly, input int mode);
    logic        hit;
    logic        sup;
    logic        completes;
    logic        exp_oe;
    logic [1:0]  exp_st;
    logic [31:0] exp_adr;
    logic [31:0] r;
    int          exp_lat;
    int          exp_cyc;
    int          cyc_seen;
    int          ack_at;
    bit          expect_resp;

    // ---- reference model ----
    hit = !attn && ((addr[31:24] == {4'hF, MY_SLOT}) ||
                    ((SUPER_EN != 0) && addr[31:28] == MY_SLOT && MY_SLOT != 4'hF));
    sup = hit && (addr[31:28] != 4'hF);
    if (sup) exp_adr = (32'h1 << 29) | ((addr & 32'h0FFF_FFFF) >> 2);
    else     exp_adr = (addr & 32'h00FF_FFFF) >> 2;
    completes   = (mode != M_NONE) && (dly <= T);
    expect_resp = hit;
    if (blk) begin
      exp_lat = 1; exp_cyc = 0; exp_st = 2'b01; exp_oe = 1'b0;
    end else begin
      exp_lat = (wr ? 3 : 2) + (completes ? dly : T);
      exp_cyc = completes ? dly + 1 : T + 1;
      exp_st  = !completes ? 2'b10 : ((mode == M_ACK) ? 2'b00 : 2'b01);
      exp_oe  = completes && (mode == M_ACK) && !wr;
    end
    if (!hit) exp_cyc = 0;

    // ---- start cycle ----
    bus.start = 1'b1;
    bus.ack   = attn;
    bus.tm1   = wr;
    bus.tm0   = 1'($urandom_range(0, 1));
    bus.ad    = addr;
    bus.sel   = bsel;
    bus.block = blk;
    cyc_seen  = 0;
    ack_at    = -1;

    for (int c = 1; c <= 40; c++) begin
      @(posedge nub_clkn);
      if (bus.wb_cyc) begin
        cyc_seen++;
        if (cyc_seen == 1) begin
          check_val({tag, "/cyc_lat"}, 32'(c), wr ? 32'd2 : 32'd1);
          check_val({tag, "/wb_adr"}, 32'(bus.wb_adr), exp_adr);
          check_val({tag, "/wb_we"}, 32'(bus.wb_we), 32'(wr));
          check_val({tag, "/wb_sel"}, 32'(bus.wb_sel), wr ? 32'(bsel) : 32'hF);
          check_val({tag, "/wb_stb"}, 32'(bus.wb_stb), 32'd1);
          if (wr) check_val({tag, "/wb_dat_w"}, bus.wb_dat_w, wdata);
        end
      end
      if (bus.ack_o && ack_at < 0) begin
        ack_at = c;
        check_val({tag, "/status"}, 32'({bus.tm1_o, bus.tm0_o}), 32'(exp_st));
        check_val({tag, "/ad_oe"}, 32'(bus.ad_oe), 32'(exp_oe));
        if (exp_oe) check_val({tag, "/ad_o"}, bus.ad_o, rdata);
      end
      if (ack_at > 0 && c == ack_at + 1) begin
        check_val({tag, "/ack_pulse"}, 32'({bus.ack_o, bus.ad_oe}), 32'd0);
        break;
      end
      if (!expect_resp && c == 8) break;

      // ---- drive next cycle ----
      r = $urandom;
      bus.ack   = 1'b0;
      bus.block = 1'b0;
      if (c == 1) begin
        bus.start = 1'b0;
        bus.ad    = wr ? wdata : r;
      end else if (hit && !blk && ack_at < 0 && (r[31:30] == 2'b00)) begin
        // a start to our own slot while busy must be ignored
        bus.start = 1'b1;
        bus.ad    = {8'hF9, r[23:0]};
      end else begin
        bus.start = 1'b0;
        bus.ad    = r;
      end
      if (bus.wb_cyc && cyc_seen > dly && mode != M_NONE) begin
        bus.wb_ack   = (mode == M_ACK) || (mode == M_BOTH);
        bus.wb_err   = (mode == M_ERR) || (mode == M_BOTH);
        bus.wb_dat_r = rdata;
      end else begin
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_dat_r = $urandom;
      end
    end
    bus.start = 1'b0;
    check_val({tag, "/cyc_cnt"}, 32'(cyc_seen), 32'(exp_cyc));
    check_val({tag, "/ack_lat"}, 32'(ack_at), expect_resp ? 32'(exp_lat) : 32'hFFFF_FFFF);
    $display("[TB] %s addr=%08h wr=%0d blk=%0d attn=%0d dly=%0d mode=%0d cyc=%0d ack_at=%0d",
             tag, addr, wr, blk, attn, dly, mode, cyc_seen, ack_at);
  endtask

  // Reset pulsed while a Wishbone cycle is open: the cycle drops at once and
  // no acknowledge follows.
  task automatic reset_mid_wb();
    bus.start = 1'b1; bus.ack = 1'b0; bus.tm1 = 1'b0; bus.block = 1'b0;
    bus.ad    = 32'hF900_0040;
    @(posedge nub_clkn);
    bus.start = 1'b0;
    @(posedge nub_clkn);
    check_val("rst/cyc_before", 32'(bus.wb_cyc), 32'd1);
    #2 nub_resetn = 1'b0;
    #1;
    check_val("rst/cyc_async", 32'({bus.wb_cyc, bus.wb_stb}), 32'd0);
    @(posedge nub_clkn);
    nub_resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge nub_clkn);
      check_val("rst/no_ack", 32'({bus.ack_o, bus.wb_cyc}), 32'd0);
    end
    $display("[TB] reset_mid_wb done");
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    logic [3:0]  other;
    int          kind;
    int          mode_pick;

    nub_resetn   = 1'b0;
    bus.nub_idn  = ~MY_SLOT;
    bus.tm0      = 1'b0;
    bus.tm1      = 1'b0;
    bus.start    = 1'b0;
    bus.ack      = 1'b0;
    bus.ad       = '0;
    bus.sel      = '0;
    bus.block    = 1'b0;
    bus.wb_dat_r = '0;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;

    @(posedge nub_clkn);
    check_val("reset/wb", 32'({bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_sel}), 32'd0);
    check_val("reset/wb_adr", 32'(bus.wb_adr), 32'd0);
    check_val("reset/wb_dat_w", bus.wb_dat_w, 32'd0);
    check_val("reset/nub", 32'({bus.ack_o, bus.tm1_o, bus.tm0_o, bus.ad_oe}), 32'd0);
    check_val("reset/ad_o", bus.ad_o, 32'd0);
    nub_resetn = 1'b1;
    @(posedge nub_clkn);

    run_txn("rd_basic",  32'hF900_1234, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, M_ACK);
    run_txn("wr_basic",  32'hF900_0010, 1'b1, 4'hF, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0, 0, M_ACK);
    run_txn("wr_byte",   32'hF900_0208, 1'b1, 4'h4, 1'b0, 1'b0, 32'h1122_3344, 32'h0, 2, M_ACK);
    run_txn("miss_slot", 32'hFA00_0000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, M_ACK);
    run_txn("attention", 32'hF900_0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0, 32'h0, 0, M_ACK);
    run_txn("miss_super", 32'hA000_0100, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, M_ACK);
    run_txn("rd_super",  32'h9000_0100, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h1357_9BDF, 2, M_ACK);
    run_txn("block",     32'hF900_0000, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, M_ACK);
    run_txn("rd_err",    32'hF900_0020, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h5555_AAAA, 1, M_ERR);
    run_txn("wr_both",   32'hF900_0024, 1'b1, 4'h3, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0, 0, M_BOTH);
    run_txn("rd_tmo",    32'hF900_0030, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, M_NONE);
    run_txn("b2b_rd",    32'hF900_0034, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'hA5A5_5A5A, 0, M_ACK);
    run_txn("ack_at_T",  32'hF900_0038, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0F0F_0F0F, T, M_ACK);
    run_txn("ack_late",  32'hF900_003C, 1'b1, 4'hF, 1'b0, 1'b0, 32'h7777_8888, 32'h0, T + 1, M_ACK);

    reset_mid_wb();
    run_txn("post_rst",  32'hF900_0044, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h2468_ACE0, 1, M_ACK);

    for (int i = 0; i < 60; i++) begin
      r     = $urandom;
      kind  = int'($urandom_range(0, 5));
      other = 4'($urandom_range(0, 15));
      if (other == MY_SLOT) other = 4'h3;
      case (kind)
        0, 1:    a = {8'hF9, r[23:0]};
        2:       a = {4'h9, r[27:0]};
        3:       a = {4'hF, other, r[23:0]};
        4:       a = {other, r[27:0]};
        default: a = r;
      endcase
      mode_pick = int'($urandom_range(0, 9));
      run_txn("rand", a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
              $urandom, $urandom, int'($urandom_range(0, 6)),
              (mode_pick < 6) ? M_ACK : (mode_pick < 8) ? M_ERR : (mode_pick < 9) ? M_BOTH : M_NONE);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
